// File: rtl/aes_cipher_param.sv
// aes_cipher_param: iterative AES encryptor with a cached round-key store.
//   A key is expanded once (one word per cycle) into 4*(Nr+1) words. Blocks
//   are then encrypted against the cached key at one round per cycle.
// Parameters: KEY_BITS = 128 | 192 | 256 (anything else fails elaboration).
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   key_in, key_load     cipher key and expansion start (sampled in IDLE only)
//   key_ready            round-key store holds a valid expanded key
//   in_valid/in_ready    plaintext handshake, plain_text (bit 127 = byte 0 MSB)
//   out_valid/out_ready  ciphertext handshake, cipher_text (same byte order)
//   busy                 FSM is not IDLE
// Optional build macro AES_CIPHER_BLK_CNT_EN adds blk_count[31:0], a count of
// ciphertext handshakes, cleared by rst and by an accepted key_load.

module aes_sbox (
    input  logic [7:0] i_a,
    output logic [7:0] o_s
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128 (0 maps to 0),
    // followed by the affine transform.
    always_comb begin
        logic [7:0] sq, inv;
        sq  = i_a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        o_s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_cipher_param #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                key_load,
    output logic                key_ready,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        plain_text,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        cipher_text,
`ifdef AES_CIPHER_BLK_CNT_EN
    output logic [31:0]         blk_count,
`endif
    output logic                busy
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_cipher_param: KEY_BITS must be 128, 192 or 256");
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_KEYEXP, S_ROUND, S_DONE} state_t;
    state_t r_fsm, w_fsm_nxt;

    logic [31:0]  r_w [NW];
    logic [5:0]   r_ki;
    logic [2:0]   r_kmod;          // r_ki mod NK, tracked incrementally
    logic [7:0]   r_rcon;
    logic         r_key_ready;
    logic [127:0] r_data, r_rk, r_ct;
    logic [3:0]   r_round;
    logic         r_rk_vld;        // r_rk holds the key for r_round
    logic         r_out_valid;

    logic [31:0]  w_prev, w_back, w_sub_in, w_sub_out, w_temp, w_new;
    logic         w_sw4, w_kexp_last, w_in_hs;
    logic [3:0]   w_fetch_rnd;
    logic [127:0] w_rk0, w_rk_fetch, w_sb, w_sr, w_mc, w_round_out;

    // ---------------- key expansion ----------------
    assign w_prev      = r_w[r_ki - 6'd1];
    assign w_back      = r_w[r_ki - 6'(NK)];
    assign w_sw4       = (NK == 8) && (r_kmod == 3'd4);
    assign w_sub_in    = w_sw4 ? w_prev : {w_prev[23:0], w_prev[31:24]};
    assign w_temp      = (r_kmod == 3'd0) ? (w_sub_out ^ {r_rcon, 24'h0}) :
                         w_sw4            ? w_sub_out : w_prev;
    assign w_new       = w_back ^ w_temp;
    assign w_kexp_last = (r_ki == 6'(NW - 1));

    for (genvar j = 0; j < 4; j++) begin : g_ksb
        aes_sbox u_sb (.i_a(w_sub_in[31-8*j -: 8]), .o_s(w_sub_out[31-8*j -: 8]));
    end

    // ---------------- round keys ----------------
    // The round key is fetched one cycle ahead into r_rk so the wide store
    // mux stays out of the S-box/MixColumns path; the first ROUND cycle only
    // primes r_rk.
    always_comb begin
        w_fetch_rnd = r_rk_vld ? r_round + 4'd1 : r_round;
        if (w_fetch_rnd > 4'(NR)) w_fetch_rnd = 4'(NR);
    end
    assign w_rk_fetch = {r_w[{w_fetch_rnd, 2'd0}], r_w[{w_fetch_rnd, 2'd1}],
                         r_w[{w_fetch_rnd, 2'd2}], r_w[{w_fetch_rnd, 2'd3}]};
    assign w_rk0      = {r_w[0], r_w[1], r_w[2], r_w[3]};

    // ---------------- round data path ----------------
    for (genvar n = 0; n < 16; n++) begin : g_dsb
        aes_sbox u_sb (.i_a(r_data[127-8*n -: 8]), .o_s(w_sb[127-8*n -: 8]));
    end

    // Byte n sits in column n/4, row n%4; row r rotates left by r columns.
    always_comb begin
        w_sr = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                w_sr[127-8*(4*c+r) -: 8] = w_sb[127-8*(4*((c+r)%4)+r) -: 8];
    end

    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        w_mc = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = w_sr[127-32*c -: 8];
            a1 = w_sr[119-32*c -: 8];
            a2 = w_sr[111-32*c -: 8];
            a3 = w_sr[103-32*c -: 8];
            w_mc[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            w_mc[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            w_mc[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            w_mc[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
    end

    assign w_round_out = ((r_round == 4'(NR)) ? w_sr : w_mc) ^ r_rk;

    // ---------------- control ----------------
    assign in_ready = (r_fsm == S_IDLE) && r_key_ready && !key_load;
    assign w_in_hs  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) r_fsm <= S_IDLE;
        else     r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:   if (key_load) w_fsm_nxt = S_KEYEXP;
                      else if (w_in_hs) w_fsm_nxt = S_ROUND;
            S_KEYEXP: if (w_kexp_last) w_fsm_nxt = S_IDLE;
            S_ROUND:  if (r_rk_vld && r_round == 4'(NR)) w_fsm_nxt = S_DONE;
            S_DONE:   if (out_ready) w_fsm_nxt = S_IDLE;
            default:  w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_ready <= 1'b0;
            r_out_valid <= 1'b0;
            r_ct        <= '0;
            r_rk_vld    <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (key_load) begin
                        for (int j = 0; j < NK; j++)
                            r_w[j] <= key_in[KEY_BITS-1-32*j -: 32];
                        r_key_ready <= 1'b0;
                        r_ki        <= 6'(NK);
                        r_kmod      <= 3'd0;
                        r_rcon      <= 8'h01;
                    end else if (w_in_hs) begin
                        r_data   <= plain_text ^ w_rk0;
                        r_round  <= 4'd1;
                        r_rk_vld <= 1'b0;
                    end
                end
                S_KEYEXP: begin
                    r_w[r_ki] <= w_new;
                    r_ki      <= r_ki + 6'd1;
                    r_kmod    <= (r_kmod == 3'(NK - 1)) ? 3'd0 : r_kmod + 3'd1;
                    if (r_kmod == 3'd0) r_rcon <= xt(r_rcon);
                    if (w_kexp_last) r_key_ready <= 1'b1;
                end
                S_ROUND: begin
                    r_rk <= w_rk_fetch;
                    if (!r_rk_vld) begin
                        r_rk_vld <= 1'b1;
                    end else if (r_round == 4'(NR)) begin
                        r_ct        <= w_round_out;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_data  <= w_round_out;
                        r_round <= r_round + 4'd1;
                    end
                end
                S_DONE: if (out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef AES_CIPHER_BLK_CNT_EN
    logic [31:0] r_blk_cnt;
    always_ff @(posedge clk) begin
        if (rst)                                r_blk_cnt <= '0;
        else if (r_fsm == S_IDLE && key_load)   r_blk_cnt <= '0;
        else if (r_out_valid && out_ready)      r_blk_cnt <= r_blk_cnt + 32'd1;
    end
    assign blk_count = r_blk_cnt;
`endif

    assign key_ready   = r_key_ready;
    assign out_valid   = r_out_valid;
    assign cipher_text = r_ct;
    assign busy        = (r_fsm != S_IDLE);
endmodule

// File: tb/tb_aes_cipher_param.sv
// Bench for aes_cipher_param: one instance per key size (128/192/256), each
// with its own driver, expected-value queue and output monitor. Expected
// ciphertexts come from FIPS-197 constants or from a byte-level AES model.
module tb_aes_cipher_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] sb [256];

    // S-box built from the generator walk over GF(2^8): p steps by 3, q by 1/3.
    initial begin : build_sbox
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    // key is left-aligned in 256 bits; nk = number of 32-bit key words.
    function automatic logic [127:0] aes_ref(input logic [255:0] key, input int nk,
                                             input logic [127:0] pt);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] out;
        int nr;
        nr  = nk + 6;
        rc  = 8'h01;
        out = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xt(rc);
            end else if (nk == 8 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int n = 0; n < 16; n++) t[n] = sb[s[n]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
            if (rnd < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*rnd + n/4][31-8*(n%4) -: 8];
        end
        for (int n = 0; n < 16; n++) out[127-8*n -: 8] = s[n];
        return out;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: timeout, expected event not seen", nm);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int KB = 128 + 64*g;
        localparam int NK = KB / 32;
        localparam int NR = NK + 6;
        localparam logic [127:0] FIPS_CT =
            (g == 0) ? 128'h69c4e0d86a7b0430d8cdb78070b4c55a :
            (g == 1) ? 128'hdda97ca4864cdfe06eaf70a0ec0d7191 :
                       128'h8ea2b7ca516745bfeafc49904b496089;

        logic          rst, key_load, key_ready, in_valid, in_ready, out_valid, out_ready, busy;
        logic [KB-1:0] key_in;
        logic [127:0]  plain_text, cipher_text;
`ifdef AES_CIPHER_BLK_CNT_EN
        logic [31:0]   blk_count;
`endif
        logic [127:0]  exp_q [$];
        bit            done = 1'b0;

        aes_cipher_param #(.KEY_BITS(KB)) u_dut (
            .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
            .key_ready(key_ready), .in_valid(in_valid), .in_ready(in_ready),
            .plain_text(plain_text), .out_valid(out_valid), .out_ready(out_ready),
            .cipher_text(cipher_text),
`ifdef AES_CIPHER_BLK_CNT_EN
            .blk_count(blk_count),
`endif
            .busy(busy)
        );

        // Monitor: every ciphertext handshake consumes one expected value.
        always @(negedge clk) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL ct%0d_unexpected: got %h, want no output", KB, cipher_text);
                end else begin
                    chk($sformatf("ct%0d", KB), cipher_text, exp_q.pop_front());
                end
            end
        end

        function automatic logic [127:0] model(input logic [KB-1:0] k, input logic [127:0] p);
            return aes_ref(256'(k) << (256 - KB), NK, p);
        endfunction

        function automatic logic [KB-1:0] rnd_key();
            logic [KB-1:0] k;
            k = '0;
            for (int j = 0; j < NK; j++) k = {k[KB-33:0], 32'($urandom)};
            return k;
        endfunction

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic wait_idle();
            int n;
            n = 0;
            while (busy && n < 200) begin step(); n++; end
            if (busy) tmo("wait_idle");
        endtask

        task automatic load_key(input logic [KB-1:0] k);
            int n;
            key_in   = k;
            key_load = 1'b1;
            step();
            key_load = 1'b0;
            n = 0;
            while (!key_ready && n < 200) begin step(); n++; end
            chk($sformatf("keyexp_cycles%0d", KB), 128'(n), 128'(4*(NR+1) - NK));
        endtask

        task automatic send(input logic [127:0] p, input logic [127:0] e,
                            input bit push, input bit meas);
            int n;
            n = 0;
            while (!in_ready && n < 200) begin step(); n++; end
            if (!in_ready) tmo("in_ready");
            plain_text = p;
            in_valid   = 1'b1;
            if (push) exp_q.push_back(e);
            step();
            in_valid = 1'b0;
            if (meas) begin
                n = 0;
                while (!out_valid && n < 100) begin step(); n++; end
                chk($sformatf("latency%0d", KB), 128'(n), 128'(NR + 1));
                wait_idle();
            end
        endtask

        initial begin : drive
            logic [KB-1:0] k, k2;
            logic [127:0]  p, e;
            int n;
            rst = 1'b1; key_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            key_in = '0; plain_text = '0;
            repeat (3) step();
            chk("rst_flags", 128'({key_ready, out_valid, busy, in_ready}), 128'h0);
            chk("rst_ct", cipher_text, 128'h0);
            rst = 1'b0;
            step();

            // FIPS-197 appendix C vector for this key size
            for (int j = 0; j < KB/8; j++) k[KB-1-8*j -: 8] = 8'(j);
            load_key(k);
            send(128'h00112233445566778899aabbccddeeff, FIPS_CT, 1'b1, 1'b1);

            // random keys, several blocks per key
            repeat (3) begin
                k = rnd_key();
                load_key(k);
                repeat (3) begin
                    p = rnd128();
                    send(p, model(k, p), 1'b1, 1'b1);
                end
            end

            // backpressure and key reuse
            k = rnd_key();
            if (KB == 128) k = KB'(128'h2b7e151628aed2a6abf7158809cf4f3c);
            p = 128'h3243f6a8885a308d313198a2e0370734;
            e = (KB == 128) ? 128'h3925841d02dc09fbdc118597196a0b32 : model(k, p);
            load_key(k);
            out_ready = 1'b0;
            send(p, e, 1'b1, 1'b0);
            n = 0;
            while (!out_valid && n < 100) begin step(); n++; end
            if (!out_valid) tmo("bp_out_valid");
            repeat (20) begin
                chk("bp_ct_hold", cipher_text, e);
                chk("bp_flags", 128'({out_valid, in_ready}), 128'h2);
                step();
            end
            out_ready = 1'b1;
            wait_idle();
            send(p, e, 1'b1, 1'b1);

            // key_load beats in_valid in IDLE
            k2 = rnd_key();
            key_in = k2; key_load = 1'b1; plain_text = rnd128(); in_valid = 1'b1;
            #1;
            chk("kl_wins_in_ready", 128'(in_ready), 128'h0);
            step();
            key_load = 1'b0; in_valid = 1'b0;
            chk("kl_busy_keyready", 128'({busy, key_ready}), 128'h2);
            n = 0;
            while (!key_ready && n < 200) begin step(); n++; end
            if (!key_ready) tmo("kl_key_ready");
            k = k2;

            // key_load during ROUND is ignored
            p = rnd128();
            send(p, model(k, p), 1'b1, 1'b0);
            repeat (3) step();
            key_in = rnd_key(); key_load = 1'b1;
            step();
            key_load = 1'b0;
            wait_idle();
            chk("round_kl_key_ready", 128'(key_ready), 128'h1);
            p = rnd128();
            send(p, model(k, p), 1'b1, 1'b1);

            // reset in the middle of an encryption aborts it
            send(rnd128(), 128'h0, 1'b0, 1'b0);
            repeat (5) step();
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk("abort_flags", 128'({out_valid, key_ready, busy}), 128'h0);
            in_valid = 1'b1;
            repeat (4) begin
                chk("abort_in_ready", 128'(in_ready), 128'h0);
                step();
            end
            in_valid = 1'b0;
            k = rnd_key();
            load_key(k);
`ifdef AES_CIPHER_BLK_CNT_EN
            chk("blk_cnt_zero", 128'(blk_count), 128'h0);
`endif
            repeat (3) begin
                p = rnd128();
                send(p, model(k, p), 1'b1, 1'b1);
            end
`ifdef AES_CIPHER_BLK_CNT_EN
            chk("blk_cnt_three", 128'(blk_count), 128'h3);
            load_key(k);
            chk("blk_cnt_cleared", 128'(blk_count), 128'h0);
`endif

            n = 0;
            while (exp_q.size() != 0 && n < 100) begin step(); n++; end
            chk("drain", 128'(exp_q.size()), 128'h0);
            done = 1'b1;
        end
    end

    initial begin : finisher
        int n;
        n = 0;
        while (!(g_dut[0].done && g_dut[1].done && g_dut[2].done) && n < 50000) begin
            @(posedge clk);
            n++;
        end
        if (!(g_dut[0].done && g_dut[1].done && g_dut[2].done)) tmo("all_done");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
